// File: rtl/acc_axis_averager.sv
// Moving-average filter for accelerometer x/y/z samples over the last 2**LOG2_DEPTH samples.
// Each accepted sample walks IDLE -> UPDATE -> OUTPUT and produces one registered average per axis.
module acc_axis_averager #(
    parameter int DATA_W     = 16,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  done_read,
    input  logic [DATA_W-1:0]     x_axis,
    input  logic [DATA_W-1:0]     y_axis,
    input  logic [DATA_W-1:0]     z_axis,
    output logic [DATA_W-1:0]     x_avg,
    output logic [DATA_W-1:0]     y_avg,
    output logic [DATA_W-1:0]     z_avg,
    output logic                  avg_valid,
    output logic                  filled,
    output logic [LOG2_DEPTH:0]   sample_count,
    output logic                  overrun
);
    localparam int DEPTH = 2 ** LOG2_DEPTH;
    localparam int SUM_W = DATA_W + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] CNT_MAX = (LOG2_DEPTH + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, UPDATE = 2'd1, OUTPUT = 2'd2} state_t;
    state_t state, state_nxt;

    logic                     done_read_q;
    logic                     sample_evt;
    logic                     flush;
    logic [LOG2_DEPTH-1:0]    wr_ptr;
    logic signed [DATA_W-1:0] hist_x [DEPTH];
    logic signed [DATA_W-1:0] hist_y [DEPTH];
    logic signed [DATA_W-1:0] hist_z [DEPTH];
    logic signed [DATA_W-1:0] new_x_p0, new_y_p0, new_z_p0;
    logic signed [DATA_W-1:0] old_x_p0, old_y_p0, old_z_p0;
    logic signed [SUM_W-1:0]  sum_x_p1, sum_y_p1, sum_z_p1;

    function automatic logic signed [SUM_W-1:0] sext(input logic signed [DATA_W-1:0] v);
        return {{LOG2_DEPTH{v[DATA_W-1]}}, v};
    endfunction

    // Arithmetic shift floors toward -inf; the window sum always fits back into DATA_W.
    function automatic logic signed [DATA_W-1:0] window_mean(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W-1:0] q;
        q = s >>> LOG2_DEPTH;
        return q[DATA_W-1:0];
    endfunction

    assign flush      = rst | clear;
    assign sample_evt = done_read & ~done_read_q;
    assign filled     = (sample_count == CNT_MAX);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sample_evt) state_nxt = UPDATE;
            UPDATE:  state_nxt = OUTPUT;
            OUTPUT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The edge register tracks done_read even during flush, so a level held across reset is not a new sample.
    always_ff @(posedge clk) begin
        done_read_q <= done_read;
        if (flush) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr       <= '0;
            sample_count <= '0;
            avg_valid    <= 1'b0;
            overrun      <= 1'b0;
            x_avg        <= '0;
            y_avg        <= '0;
            z_avg        <= '0;
            new_x_p0     <= '0;
            new_y_p0     <= '0;
            new_z_p0     <= '0;
            old_x_p0     <= '0;
            old_y_p0     <= '0;
            old_z_p0     <= '0;
            sum_x_p1     <= '0;
            sum_y_p1     <= '0;
            sum_z_p1     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                hist_x[i] <= '0;
                hist_y[i] <= '0;
                hist_z[i] <= '0;
            end
        end else begin
            avg_valid <= 1'b0;
            overrun   <= sample_evt && (state != IDLE);
            case (state)
                // p0: capture the new sample and the one it evicts
                IDLE: begin
                    if (sample_evt) begin
                        new_x_p0 <= x_axis;
                        new_y_p0 <= y_axis;
                        new_z_p0 <= z_axis;
                        old_x_p0 <= hist_x[wr_ptr];
                        old_y_p0 <= hist_y[wr_ptr];
                        old_z_p0 <= hist_z[wr_ptr];
                    end
                end
                // p1: running window sums and history write-back
                UPDATE: begin
                    sum_x_p1       <= sum_x_p1 - sext(old_x_p0) + sext(new_x_p0);
                    sum_y_p1       <= sum_y_p1 - sext(old_y_p0) + sext(new_y_p0);
                    sum_z_p1       <= sum_z_p1 - sext(old_z_p0) + sext(new_z_p0);
                    hist_x[wr_ptr] <= new_x_p0;
                    hist_y[wr_ptr] <= new_y_p0;
                    hist_z[wr_ptr] <= new_z_p0;
                    wr_ptr         <= wr_ptr + 1'b1;
                    if (sample_count != CNT_MAX) sample_count <= sample_count + 1'b1;
                end
                // p2: registered averages
                OUTPUT: begin
                    x_avg     <= window_mean(sum_x_p1);
                    y_avg     <= window_mean(sum_y_p1);
                    z_avg     <= window_mean(sum_z_p1);
                    avg_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_axis_averager.sv
// Self-checking bench for acc_axis_averager: directed scenarios plus random traffic
// compared against a sample-level moving-average model.
module tb_acc_axis_averager;
    localparam int DATA_W = 16;
    localparam int LOG2_DEPTH = 3;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst, clear, done_read;
    logic [DATA_W-1:0] x_axis, y_axis, z_axis;
    logic signed [DATA_W-1:0] x_avg, y_avg, z_avg;
    logic avg_valid, filled, overrun;
    logic [LOG2_DEPTH:0] sample_count;

    acc_axis_averager #(.DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH)) dut (
        .clk(clk), .rst(rst), .clear(clear), .done_read(done_read),
        .x_axis(x_axis), .y_axis(y_axis), .z_axis(z_axis),
        .x_avg(x_avg), .y_avg(y_avg), .z_avg(z_avg),
        .avg_valid(avg_valid), .filled(filled),
        .sample_count(sample_count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {int cyc; int x; int y; int z; int cnt;} exp_t;
    exp_t sb[$];
    bit   ovr_exp[int];
    int   qx[$], qy[$], qz[$];
    int   m_count = 0;
    int   last_acc = -100;
    bit   mon_en = 0;
    logic exp_v;

    function automatic int window_avg(input int q[$]);
        int s;
        s = 0;
        foreach (q[i]) s += q[i];
        if (s >= 0) return s / DEPTH;
        return -((-s + DEPTH - 1) / DEPTH);
    endfunction

    function automatic int rnd16();
        logic [15:0] r;
        r = 16'($urandom);
        return int'($signed(r));
    endfunction

    task automatic model_reset(input int c);
        qx.delete(); qy.delete(); qz.delete();
        m_count = 0;
        last_acc = -100;
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].cyc >= c) sb.delete(i);
    endtask

    // Called at a negedge; raises done_read for one clock and returns at the following negedge.
    task automatic send(input int x, input int y, input int z);
        int k;
        exp_t e;
        k = cyc + 1;
        x_axis = 16'(x); y_axis = 16'(y); z_axis = 16'(z);
        done_read = 1'b1;
        if (k - last_acc >= 3) begin
            last_acc = k;
            qx.push_back(x); qy.push_back(y); qz.push_back(z);
            if (qx.size() > DEPTH) begin
                void'(qx.pop_front()); void'(qy.pop_front()); void'(qz.pop_front());
            end
            if (m_count < DEPTH) m_count++;
            e.cyc = k + 2; e.x = window_avg(qx); e.y = window_avg(qy); e.z = window_avg(qz);
            e.cnt = m_count;
            sb.push_back(e);
        end else begin
            ovr_exp[k] = 1'b1;
        end
        @(negedge clk);
        done_read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic flush(input bit use_rst, input bit with_event);
        model_reset(cyc + 1);
        if (use_rst) rst = 1'b1; else clear = 1'b1;
        if (with_event) begin
            x_axis = 16'(rnd16());
            done_read = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0; clear = 1'b0; done_read = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
            check_val("avg_valid", int'(avg_valid), int'(exp_v));
            if (exp_v && avg_valid) begin
                check_val("x_avg", int'(x_avg), sb[0].x);
                check_val("y_avg", int'(y_avg), sb[0].y);
                check_val("z_avg", int'(z_avg), sb[0].z);
                check_val("sample_count", int'(sample_count), sb[0].cnt);
                check_val("filled", int'(filled), int'(sb[0].cnt == DEPTH));
            end
            if (exp_v) void'(sb.pop_front());
            check_val("overrun", int'(overrun), int'(ovr_exp.exists(cyc)));
        end
    end

    initial begin
        rst = 1'b1; clear = 1'b0; done_read = 1'b1;
        x_axis = '0; y_axis = '0; z_axis = '0;

        // Reset for two clocks with done_read held high across release.
        @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        check_val("rst x_avg", int'(x_avg), 0);
        check_val("rst y_avg", int'(y_avg), 0);
        check_val("rst z_avg", int'(z_avg), 0);
        check_val("rst count", int'(sample_count), 0);
        check_val("rst filled", int'(filled), 0);
        rst = 1'b0;
        idle(6);
        done_read = 1'b0;
        idle(2);
        check_val("held count", int'(sample_count), 0);

        // Eight identical samples fill the window.
        for (int i = 0; i < 8; i++) begin
            send(100, -100, 0);
            idle(2);
        end
        idle(1);
        check_val("fill x_avg", int'(x_avg), 100);
        check_val("fill y_avg", int'(y_avg), -100);
        check_val("fill filled", int'(filled), 1);

        // Window wrap: 800s then zeros drain the average.
        flush(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            send((i < 8) ? 800 : 0, 0, 0);
            idle(2);
        end
        idle(1);
        check_val("wrap x_avg", int'(x_avg), 0);

        // Full-scale extremes.
        flush(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send(32767, -32768, 1);
            idle(2);
        end
        idle(1);
        check_val("max x_avg", int'(x_avg), 32767);
        for (int i = 0; i < 8; i++) begin
            send(-32768, 32767, -1);
            idle(2);
        end
        idle(1);
        check_val("min x_avg", int'(x_avg), -32768);

        // Second rising edge two clocks after the first is dropped.
        flush(1'b0, 1'b0);
        send(40, 0, 0);
        idle(1);
        send(500, 0, 0);
        idle(4);
        check_val("overrun count", int'(sample_count), 1);

        // Clear during the update cycle aborts the sample.
        flush(1'b0, 1'b0);
        send(80, 0, 0);
        flush(1'b0, 1'b0);
        idle(4);
        check_val("abort count", int'(sample_count), 0);
        send(80, 0, 0);
        idle(3);
        check_val("after abort x_avg", int'(x_avg), 10);

        // Clear coinciding with a rising edge: edge discarded, no overrun.
        flush(1'b0, 1'b1);
        idle(4);
        check_val("clr+evt count", int'(sample_count), 0);

        // Random traffic with occasional flushes and rate violations.
        for (int n = 0; n < 120; n++) begin
            int r;
            r = $urandom_range(0, 24);
            if (r == 0)      flush(1'b0, 1'b0);
            else if (r == 1) flush(1'b1, 1'b0);
            else if (r == 2) flush(1'b0, 1'b1);
            else             send(rnd16(), rnd16(), rnd16());
            idle($urandom_range(1, 4));
        end
        idle(6);
        check_val("scoreboard drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
